// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core load/store
// path (requester 0) and the program loader (requester 1), one transaction in flight.
module dmem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic              r_win;
  logic              r_we;

  logic              w_any;
  logic              w_pick;
  logic              w_issue;
  logic              w_cap;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              w_m_en_nxt;
  logic              w_m_we_nxt;
  logic [ADDR_W-1:0] w_m_addr_nxt;
  logic [DATA_W-1:0] w_m_wdata_nxt;
  logic              w_r0_gnt_nxt;
  logic              w_r1_gnt_nxt;
  logic              w_r0_rvalid_nxt;
  logic              w_r1_rvalid_nxt;

  logic              r_m_en;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_r0_gnt;
  logic              r_r1_gnt;
  logic              r_r0_rvalid;
  logic              r_r1_rvalid;
  logic [DATA_W-1:0] r_r0_rdata;
  logic [DATA_W-1:0] r_r1_rdata;

  // On a tie the requester that did not win last time gets the memory.
  assign w_any       = r0_req | r1_req;
  assign w_pick      = (r0_req && r1_req) ? ~r_last : r1_req;
  assign w_sel_we    = w_pick ? r1_we    : r0_we;
  assign w_sel_addr  = w_pick ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_pick ? r1_wdata : r0_wdata;
  assign w_issue     = (r_state == S_IDLE) && w_any;
  assign w_cap       = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_win  <= w_pick;
        r_we   <= w_sel_we;
        r_last <= w_pick;
      end
      if (r_state == S_ISSUE && !r_we) begin
        r_cnt <= CNT_W'(MEM_LAT);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Every output is a flop, so this computes the values they take on the next edge.
  always_comb begin
    w_m_en_nxt      = w_issue;
    w_m_we_nxt      = w_issue & w_sel_we;
    w_m_addr_nxt    = w_issue ? w_sel_addr  : '0;
    w_m_wdata_nxt   = w_issue ? w_sel_wdata : '0;
    w_r0_gnt_nxt    = w_issue & ~w_pick;
    w_r1_gnt_nxt    = w_issue &  w_pick;
    w_r0_rvalid_nxt = w_cap & ~r_win;
    w_r1_rvalid_nxt = w_cap &  r_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_en      <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_r0_gnt    <= 1'b0;
      r_r1_gnt    <= 1'b0;
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_r0_rdata  <= '0;
      r_r1_rdata  <= '0;
    end else begin
      r_m_en      <= w_m_en_nxt;
      r_m_we      <= w_m_we_nxt;
      r_m_addr    <= w_m_addr_nxt;
      r_m_wdata   <= w_m_wdata_nxt;
      r_r0_gnt    <= w_r0_gnt_nxt;
      r_r1_gnt    <= w_r1_gnt_nxt;
      r_r0_rvalid <= w_r0_rvalid_nxt;
      r_r1_rvalid <= w_r1_rvalid_nxt;
      if (w_r0_rvalid_nxt) r_r0_rdata <= m_rdata;
      if (w_r1_rvalid_nxt) r_r1_rdata <= m_rdata;
    end
  end

  assign m_en      = r_m_en;
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign r0_gnt    = r_r0_gnt;
  assign r1_gnt    = r_r1_gnt;
  assign r0_rvalid = r_r0_rvalid;
  assign r1_rvalid = r_r1_rvalid;
  assign r0_rdata  = r_r0_rdata;
  assign r1_rdata  = r_r1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances (MEM_LAT 1..4) with behavioural memories,
// read results predicted from a shadow memory and held in a scoreboard queue.
module tb_dmem_arbiter;

  typedef struct {
    int          who;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;

  logic        r0_req[4], r0_we[4], r1_req[4], r1_we[4];
  logic [9:0]  r0_addr[4], r1_addr[4];
  logic [31:0] r0_wdata[4], r1_wdata[4];
  logic        r0_gnt[4], r0_rvalid[4], r1_gnt[4], r1_rvalid[4];
  logic [31:0] r0_rdata[4], r1_rdata[4];
  logic        m_en[4], m_we[4];
  logic [9:0]  m_addr[4];
  logic [31:0] m_wdata[4], m_rdata[4];

  logic [31:0] shadow[4][1024];
  logic [31:0] exp_rd[4][2];
  sb_t         sb_q[$];
  int          errs;
  int          checks;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'h0, a};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    logic [31:0] mem [1024];
    logic [31:0] pipe [g+1];

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
      end else if (m_en[g] && m_we[g]) begin
        mem[m_addr[g]] <= m_wdata[g];
      end
      pipe[0] <= mem[m_addr[g]];
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
    end
    assign m_rdata[g] = pipe[g];

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req[g]), .r0_we(r0_we[g]), .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
      .r0_gnt(r0_gnt[g]), .r0_rvalid(r0_rvalid[g]), .r0_rdata(r0_rdata[g]),
      .r1_req(r1_req[g]), .r1_we(r1_we[g]), .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
      .r1_gnt(r1_gnt[g]), .r1_rvalid(r1_rvalid[g]), .r1_rdata(r1_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g])
    );
  end

  function automatic logic [127:0] outs(input int g);
    logic [127:0] v;
    v = {16'h0, r0_gnt[g], r0_rvalid[g], r0_rdata[g], r1_gnt[g], r1_rvalid[g], r1_rdata[g],
         m_en[g], m_we[g], m_addr[g], m_wdata[g]};
    return v;
  endfunction

  function automatic logic rv_of(input int g, input int who);
    return (who == 1) ? r1_rvalid[g] : r0_rvalid[g];
  endfunction

  function automatic logic gnt_of(input int g, input int who);
    return (who == 1) ? r1_gnt[g] : r0_gnt[g];
  endfunction

  function automatic logic [31:0] rd_of(input int g, input int who);
    return (who == 1) ? r1_rdata[g] : r0_rdata[g];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int g, input int who, input logic we, input logic [9:0] a,
                         input logic [31:0] d);
    if (who == 1) begin
      r1_req[g] = 1'b1; r1_we[g] = we; r1_addr[g] = a; r1_wdata[g] = d;
    end else begin
      r0_req[g] = 1'b1; r0_we[g] = we; r0_addr[g] = a; r0_wdata[g] = d;
    end
  endtask

  task automatic clr_req(input int g, input int who);
    if (who == 1) begin
      r1_req[g] = 1'b0; r1_we[g] = 1'b0; r1_addr[g] = '0; r1_wdata[g] = '0;
    end else begin
      r0_req[g] = 1'b0; r0_we[g] = 1'b0; r0_addr[g] = '0; r0_wdata[g] = '0;
    end
  endtask

  // Called at the negedge of the grant cycle (T+1); rvalid is due at T+2+lat.
  task automatic wait_rv(input int g, input int who, input int lat, input bit once,
                         input string tag);
    int  n;
    bit  seen;
    sb_t e;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 16) begin
      @(negedge clk);
      n++;
      seen = rv_of(g, who);
    end
    chk({tag, "_lat"}, n, 2 + lat);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (seen) begin
        chk({tag, "_data"}, rd_of(g, who), e.data);
        exp_rd[g][who] = e.data;
      end
    end
    chk({tag, "_other"}, rd_of(g, 1 - who), exp_rd[g][1 - who]);
    if (once) begin
      @(negedge clk);
      chk({tag, "_once"}, rv_of(g, who), 1'b0);
    end
  endtask

  task automatic do_read(input int g, input int who, input logic [9:0] a, input string tag);
    sb_t e;
    e.who = who;
    e.data = shadow[g][a];
    sb_q.push_back(e);
    set_req(g, who, 1'b0, a, 32'h0);
    @(negedge clk);
    chk({tag, "_gnt"}, gnt_of(g, who), 1'b1);
    clr_req(g, who);
    wait_rv(g, who, g + 1, 1'b1, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ng;
    int  nv;
    int  n;
    sb_t e;
    errs = 0;
    checks = 0;
    rst = 1'b0;
    mem_init = 1'b1;
    for (int g = 0; g < 4; g++) begin
      clr_req(g, 0);
      clr_req(g, 1);
      exp_rd[g][0] = '0;
      exp_rd[g][1] = '0;
      for (int i = 0; i < 1024; i++) shadow[g][i] = init_word(10'(i));
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) chk("reset_outputs", outs(g), '0);
    mem_init = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Reset while an r1 read sits in WAIT
    set_req(1, 1, 1'b0, 10'h020, 32'h0);
    @(negedge clk);
    chk("rst_pre_gnt", r1_gnt[1], 1'b1);
    clr_req(1, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_async", outs(1), '0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", outs(1), '0);
    end
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_rvalid", r1_rvalid[1], 1'b0);
    end

    // r0 write, then r1 reads it back with the request accepted at T+2
    set_req(1, 0, 1'b1, 10'h010, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_gnt", r0_gnt[1], 1'b1);
    chk("wr_r1_gnt", r1_gnt[1], 1'b0);
    chk("wr_m_en", m_en[1], 1'b1);
    chk("wr_m_we", m_we[1], 1'b1);
    chk("wr_m_addr", m_addr[1], 10'h010);
    chk("wr_m_wdata", m_wdata[1], 32'hDEADBEEF);
    clr_req(1, 0);
    shadow[1][10'h010] = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_m_en_off", m_en[1], 1'b0);
    chk("wr_m_addr_off", m_addr[1], 10'h0);
    chk("wr_no_rvalid", r0_rvalid[1], 1'b0);
    do_read(1, 1, 10'h010, "r1_rd");

    // Both requesters reading continuously: grants alternate r0, r1, r0, r1
    for (int k = 0; k < 4; k++) begin
      e.who = k % 2;
      e.data = shadow[1][(k % 2 == 1) ? 10'h002 : 10'h001];
      sb_q.push_back(e);
    end
    set_req(1, 0, 1'b0, 10'h001, 32'h0);
    set_req(1, 1, 1'b0, 10'h002, 32'h0);
    ng = 0;
    nv = 0;
    n = 0;
    while (nv < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (r0_gnt[1] || r1_gnt[1]) begin
        chk("alt_gnt_order", {r0_gnt[1], r1_gnt[1]}, (ng % 2 == 1) ? 2'b01 : 2'b10);
        ng++;
        if (ng == 4) begin
          clr_req(1, 0);
          clr_req(1, 1);
        end
      end
      if ((r0_rvalid[1] || r1_rvalid[1]) && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("alt_rv_who", {r0_rvalid[1], r1_rvalid[1]}, (e.who == 1) ? 2'b01 : 2'b10);
        chk("alt_rv_data", rd_of(1, e.who), e.data);
        exp_rd[1][e.who] = e.data;
        nv++;
      end
    end
    chk("alt_done", nv, 4);
    clr_req(1, 0);
    clr_req(1, 1);
    @(negedge clk);

    // Read latency sweep, one instance per MEM_LAT
    for (int g = 0; g < 4; g++) do_read(g, 0, 10'(32 + g), "sweep");

    // r1 request rises in the IDLE cycle where r0's read completes
    e.who = 0;
    e.data = shadow[1][10'h005];
    sb_q.push_back(e);
    set_req(1, 0, 1'b0, 10'h005, 32'h0);
    @(negedge clk);
    chk("ov_r0_gnt", r0_gnt[1], 1'b1);
    clr_req(1, 0);
    wait_rv(1, 0, 2, 1'b0, "ov_r0");
    e.who = 1;
    e.data = shadow[1][10'h002];
    sb_q.push_back(e);
    set_req(1, 1, 1'b0, 10'h002, 32'h0);
    @(negedge clk);
    chk("ov_r1_gnt", r1_gnt[1], 1'b1);
    chk("ov_m_addr", m_addr[1], 10'h002);
    chk("ov_r0_once", r0_rvalid[1], 1'b0);
    clr_req(1, 1);
    wait_rv(1, 1, 2, 1'b1, "ov_r1");
    chk("ov_r0_no_dup", r0_rvalid[1], 1'b0);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - Requester 0 is the core load/store path of Data_path.
  - Requester 1 is the program/data loader, which preloads and inspects memory.
- Serialises accesses with round-robin arbitration and supports one outstanding transaction.
- Hides the memory's fixed read latency behind a valid pulse back to the requester that issued the read.

Parameters:
ADDR_W, 10, word-address width
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles from m_en to m_rdata valid; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
r0_req  in  1  requester 0 access request; held high until r0_gnt
r0_we  in  1  requester 0 write enable (1=write, 0=read)
r0_addr  in  ADDR_W  requester 0 word address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  one-cycle pulse: requester 0 command issued to memory
r0_rvalid  out  1  one-cycle pulse: r0_rdata holds requester 0 read result
r0_rdata  out  DATA_W  requester 0 read data, registered
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as requester 0, for requester 1
m_en  out  1  memory access strobe
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_en

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - all outputs 0; state=IDLE; wait counter=0; last_gnt=1, so r0 wins the first tie.
  - An in-flight read is discarded: no rvalid is produced for it after reset releases.
- All outputs are registered.
- m_we, m_addr and m_wdata are 0 whenever m_en=0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Samples r0_req and r1_req.
  - Only one requesting: that requester wins.
  - Both requesting: the requester other than last_gnt wins.
  - On a win: latch winner id, we, addr and wdata; update last_gnt; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE, exactly 1 cycle:
  - m_en=1, with m_we/m_addr/m_wdata taken from the latch; winner gnt=1.
  - Write: next state IDLE.
  - Read: next state WAIT, counter loaded with MEM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle counter==1, capture m_rdata into the winner's rdata register and go to IDLE.
  - The winner's rvalid=1 for the following cycle only.
- Timing, with T = the IDLE cycle that samples the request:
  - gnt and m_en at T+1.
  - Write complete; new sample possible at T+2.
  - Read: rvalid at T+2+MEM_LAT.
  - Write throughput: 1 access per 2 cycles.
  - Read throughput: 1 access per MEM_LAT+2 cycles.
- rvalid for a completed read and a new sample/latch may occur in the same IDLE cycle. The new command's gnt follows at the next cycle as normal.
- rN_rdata holds its value until the next read completion for requester N. The non-winner's rdata never changes.
- Requesters must hold req, we, addr and wdata stable until gnt. Once latched, a command is never cancelled: dropping req after the sample cycle does not abort it.
- A requester reasserting req in the cycle after its gnt is a new request.
- No address range checking. Writes never produce rvalid.
- Starvation bound: with both requesters requesting continuously, each is granted at least every second transaction.

Test Plan:
- Reset: assert rst=0 during WAIT of an r1 read (MEM_LAT=2), release after 3 cycles -> all outputs 0 throughout; r1_rvalid never pulses; first r0 request afterwards is granted normally.
- r0 write addr 0x010 data 0xDEADBEEF sampled at T -> at T+1: m_en=1, m_we=1, m_addr=0x010, m_wdata=0xDEADBEEF, r0_gnt=1; at T+2: m_en=0 and a new request is accepted.
- MEM_LAT=2, memory model preloaded with 0xDEADBEEF at 0x010; r1 read addr 0x010 sampled at T -> r1_gnt at T+1; r1_rvalid=1 with r1_rdata=0xDEADBEEF at T+4; r0_rdata unchanged.
- Both requesters issue continuous reads to 0x001 (r0) and 0x002 (r1) after reset -> grants alternate r0, r1, r0, r1; each rvalid carries the matching address's data.
- MEM_LAT sweep 1..4, single r0 read -> r0_rvalid exactly at T+2+MEM_LAT; exactly one pulse per read.
- r0 read completes (rvalid) in the same IDLE cycle r1_req rises -> r1 is latched that cycle and r1_gnt fires the next cycle; no lost or duplicated request.
